// File: rtl/i2c_temp_sensor_responder_pkg.sv
// Shared definitions for the TMP101-style I2C temperature sensor responder.
package i2c_temp_sensor_responder_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE_PTR,
        WRITE_ACK,
        READ_MSB,
        READ_LSB,
        WAIT_STOP,
        IGNORE
    } state_t;

    localparam logic [3:0] TMP101_DEVICE_ID = 4'b1001;
    localparam logic [7:0] PTR_TEMPERATURE  = 8'h00;

endpackage

// File: rtl/i2c_bus_conditioner.sv
// Synchronizes SCL/SDA into the clock domain and flags SCL edges plus START/STOP.
module i2c_bus_conditioner #(
    parameter int SyncStages = 2
) (
    input  logic clock,
    input  logic Reset,
    input  logic SCL,
    input  logic SDA,
    output logic SclRise,
    output logic SclFall,
    output logic StartSeen,
    output logic StopSeen,
    output logic SdaSync
);

    logic [SyncStages-1:0] scl_sync;
    logic [SyncStages-1:0] sda_sync;
    logic                  scl_prev;
    logic                  sda_prev;
    logic                  scl_now;
    logic                  sda_now;

    // Idle bus is high on both lines, so reset there to avoid a phantom edge.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SyncStages-2:0], SCL};
            sda_sync <= {sda_sync[SyncStages-2:0], SDA};
            scl_prev <= scl_sync[SyncStages-1];
            sda_prev <= sda_sync[SyncStages-1];
        end
    end

    assign scl_now   = scl_sync[SyncStages-1];
    assign sda_now   = sda_sync[SyncStages-1];
    assign SclRise   = scl_now & ~scl_prev;
    assign SclFall   = ~scl_now & scl_prev;
    assign StartSeen = scl_now & scl_prev & sda_prev & ~sda_now;
    assign StopSeen  = scl_now & scl_prev & ~sda_prev & sda_now;
    assign SdaSync   = sda_now;

endmodule

// File: rtl/i2c_temp_sensor_responder.sv
// I2C slave emulating a TMP101: returns a 16-bit temperature, accepts a pointer byte.
module i2c_temp_sensor_responder
    import i2c_temp_sensor_responder_pkg::*;
#(
    parameter int         SyncStages = 2,
    parameter logic [3:0] DeviceID   = TMP101_DEVICE_ID
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic [2:0]  ChipSelect,
    input  logic [15:0] Temperature,
    input  logic        SCL,
    inout  wire         SDA,
    output logic [7:0]  Pointer,
    output logic        Busy,
    output logic        ReadDone
);

    logic scl_rise, scl_fall, start_seen, stop_seen, sda_sync;

    i2c_bus_conditioner #(.SyncStages(SyncStages)) u_cond (
        .clock     (clock),
        .Reset     (Reset),
        .SCL       (SCL),
        .SDA       (SDA),
        .SclRise   (scl_rise),
        .SclFall   (scl_fall),
        .StartSeen (start_seen),
        .StopSeen  (stop_seen),
        .SdaSync   (sda_sync)
    );

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        ninth, ninth_nxt;
    logic [6:0]  shift, shift_nxt;
    logic        drive_low, drive_nxt;
    logic [7:0]  pointer_nxt;
    logic        busy_nxt, done_nxt;
    logic        rw, rw_nxt;
    logic        ptr_done, ptr_done_nxt;
    logic        latch;
    logic [15:0] holding;
    logic [7:0]  cur_byte;

    assign SDA      = drive_low ? 1'b0 : 1'bz;
    assign cur_byte = (state == READ_LSB) ? holding[7:0] : holding[15:8];

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ninth_nxt    = ninth;
        shift_nxt    = shift;
        drive_nxt    = drive_low;
        pointer_nxt  = Pointer;
        busy_nxt     = Busy;
        done_nxt     = 1'b0;
        rw_nxt       = rw;
        ptr_done_nxt = ptr_done;
        latch        = 1'b0;

        // Bus conditions override everything, including a byte in flight.
        if (stop_seen) begin
            state_nxt = IDLE;
            drive_nxt = 1'b0;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
            ninth_nxt = 1'b0;
        end else if (start_seen) begin
            state_nxt    = ADDR;
            drive_nxt    = 1'b0;
            busy_nxt     = 1'b0;
            cnt_nxt      = '0;
            ninth_nxt    = 1'b0;
            shift_nxt    = '0;
            ptr_done_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt = {shift[5:0], sda_sync};
                        cnt_nxt   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rw_nxt = sda_sync;
                            if (shift == {DeviceID, ChipSelect}) begin
                                state_nxt = ADDR_ACK;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ninth) begin
                            drive_nxt = 1'b1;
                            ninth_nxt = 1'b1;
                        end else begin
                            drive_nxt = 1'b0;
                            ninth_nxt = 1'b0;
                            cnt_nxt   = '0;
                            if (state == ADDR_ACK && rw) begin
                                // Both bytes of this read come from this one sample.
                                state_nxt = READ_MSB;
                                latch     = 1'b1;
                                drive_nxt = ~Temperature[15];
                            end else begin
                                state_nxt = WRITE_PTR;
                            end
                        end
                    end
                end
                WRITE_PTR: begin
                    if (scl_rise) begin
                        shift_nxt = {shift[5:0], sda_sync};
                        cnt_nxt   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state_nxt = WRITE_ACK;
                            if (!ptr_done) begin
                                pointer_nxt  = {shift, sda_sync};
                                ptr_done_nxt = 1'b1;
                            end
                        end
                    end
                end
                READ_MSB, READ_LSB: begin
                    // ninth on a falling edge means the master ACKed: start the next byte.
                    if (scl_fall) begin
                        if (ninth) begin
                            cnt_nxt   = '0;
                            ninth_nxt = 1'b0;
                            drive_nxt = ~cur_byte[7];
                        end else if (cnt == 3'd7) begin
                            drive_nxt = 1'b0;
                            ninth_nxt = 1'b1;
                        end else begin
                            cnt_nxt   = cnt + 3'd1;
                            drive_nxt = ~cur_byte[3'd6 - cnt];
                        end
                    end else if (scl_rise && ninth) begin
                        if (sda_sync) begin
                            state_nxt = WAIT_STOP;
                            ninth_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = (state == READ_MSB) ? READ_LSB : READ_MSB;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ninth     <= 1'b0;
            shift     <= '0;
            drive_low <= 1'b0;
            Pointer   <= PTR_TEMPERATURE;
            Busy      <= 1'b0;
            ReadDone  <= 1'b0;
            rw        <= 1'b0;
            ptr_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ninth     <= ninth_nxt;
            shift     <= shift_nxt;
            drive_low <= drive_nxt;
            Pointer   <= pointer_nxt;
            Busy      <= busy_nxt;
            ReadDone  <= done_nxt;
            rw        <= rw_nxt;
            ptr_done  <= ptr_done_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (latch) holding <= Temperature;
    end

endmodule

// File: tb/tb_i2c_temp_sensor_responder.sv
// Bench: bit-banged I2C master, behavioural sensor model and a scoreboard on the received bits.
`timescale 1ns/1ps
module tb_i2c_temp_sensor_responder;

    localparam int Q = 8;

    logic        clock = 1'b0;
    logic        Reset = 1'b0;
    logic [2:0]  ChipSelect = 3'd0;
    logic [15:0] Temperature = 16'h0000;
    logic        SCL = 1'b1;
    logic        m_low = 1'b0;
    wire         SDA;
    logic [7:0]  Pointer;
    logic        Busy;
    logic        ReadDone;

    pullup (SDA);
    assign SDA = m_low ? 1'b0 : 1'bz;

    always #6 clock = ~clock;

    i2c_temp_sensor_responder dut (
        .clock       (clock),
        .Reset       (Reset),
        .ChipSelect  (ChipSelect),
        .Temperature (Temperature),
        .SCL         (SCL),
        .SDA         (SDA),
        .Pointer     (Pointer),
        .Busy        (Busy),
        .ReadDone    (ReadDone)
    );

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int low_cnt = 0;
    int exp_done = 0;
    logic [7:0] model_ptr = 8'h00;

    string exp_name[$];
    int    exp_val[$];
    int    obs_val[$];
    event  obs_ev;

    always @(posedge clock) begin
        if (ReadDone) rd_cnt <= rd_cnt + 1;
        if (!m_low && SDA === 1'b0) low_cnt <= low_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_item(input string name, input int v);
        exp_name.push_back(name);
        exp_val.push_back(v);
    endtask

    task automatic observe(input int v);
        obs_val.push_back(v);
        -> obs_ev;
    endtask

    initial begin
        forever begin
            @(obs_ev);
            while (obs_val.size() != 0) begin
                int o;
                o = obs_val.pop_front();
                if (exp_name.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h, expected nothing", o);
                end else begin
                    check(exp_name.pop_front(), o, exp_val.pop_front());
                end
            end
        end
    end

    initial begin
        #1100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_start();
        SCL = 1'b1;
        m_low = 1'b0;
        tick(Q);
        m_low = 1'b1;
        tick(Q);
        SCL = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        tick(Q);
        SCL = 1'b1;
        tick(Q);
        m_low = 1'b0;
        tick(2 * Q);
    endtask

    task automatic write_bit(input bit b);
        m_low = !b;
        tick(Q);
        SCL = 1'b1;
        tick(2 * Q);
        SCL = 1'b0;
        tick(Q);
    endtask

    task automatic read_bit(output bit b);
        m_low = 1'b0;
        tick(Q);
        SCL = 1'b1;
        tick(Q);
        b = (SDA === 1'b0) ? 1'b0 : 1'b1;
        tick(Q);
        SCL = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input bit nack);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    // Reference behaviour: ACK iff address matches; reads alternate MSB/LSB of the
    // value sampled at address time; the first write byte becomes the pointer.
    task automatic transaction(input logic [6:0] a7, input bit rd, input int nbytes,
                               input logic [7:0] wr0, input bit chg, input logic [15:0] new_temp);
        logic [7:0]  d;
        logic [7:0]  wb;
        logic [15:0] snap;
        bit          match;
        bit          ack;
        match = (a7 == {4'b1001, ChipSelect});
        snap  = Temperature;
        bus_start();
        expect_item("addr_ack", match ? 0 : 1);
        write_byte({a7, rd}, ack);
        observe(int'(ack));
        check("busy_after_addr", int'(Busy), int'(match));
        if (match && rd) begin
            for (int i = 0; i < nbytes; i++) begin
                expect_item((i % 2 == 0) ? "read_msb" : "read_lsb",
                            (i % 2 == 0) ? int'(snap[15:8]) : int'(snap[7:0]));
                read_byte(d, i == nbytes - 1);
                observe(int'(d));
                if (chg && i == 0) begin
                    Temperature = new_temp;
                    ChipSelect  = 3'($urandom);
                end
            end
            exp_done++;
        end else if (match) begin
            for (int i = 0; i < nbytes; i++) begin
                wb = (i == 0) ? wr0 : 8'($urandom);
                if (i == 0) model_ptr = wb;
                expect_item("write_ack", 0);
                write_byte(wb, ack);
                observe(int'(ack));
                if (chg && i == 0) ChipSelect = 3'($urandom);
            end
        end
        bus_stop();
        check("busy_after_stop", int'(Busy), 0);
        check("pointer", int'(Pointer), int'(model_ptr));
        check("readdone_count", rd_cnt, exp_done);
    endtask

    initial begin
        int          low_before;
        bit          b;
        logic [7:0]  d;
        logic [6:0]  a7;
        logic [7:0]  abort_msb;

        Reset = 1'b0;
        tick(3);
        check("reset_busy", int'(Busy), 0);
        check("reset_pointer", int'(Pointer), 0);
        check("reset_readdone", int'(ReadDone), 0);
        check("reset_sda", int'(SDA === 1'b0), 0);
        Reset = 1'b1;
        tick(4 * Q);

        // Read hit
        ChipSelect  = 3'b010;
        Temperature = 16'h1A80;
        transaction(7'h4A, 1'b1, 2, 8'h00, 1'b0, 16'h0000);

        // Address miss: slave must never pull SDA low
        ChipSelect = 3'b000;
        low_before = low_cnt;
        transaction(7'h49, 1'b1, 2, 8'h00, 1'b0, 16'h0000);
        check("miss_sda_never_low", low_cnt - low_before, 0);

        // Pointer write
        ChipSelect = 3'b010;
        transaction(7'h4A, 1'b0, 2, 8'h01, 1'b0, 16'h0000);

        // Coherence: temperature changes between MSB and LSB
        Temperature = 16'h1900;
        transaction(7'h4A, 1'b1, 2, 8'h00, 1'b1, 16'h1AFF);

        // Abort with STOP after 4 data bits of the MSB, then a fresh read
        ChipSelect  = 3'b010;
        Temperature = 16'h1A80;
        abort_msb   = 8'h1A;
        bus_start();
        expect_item("abort_addr_ack", 0);
        write_byte(8'h95, b);
        observe(int'(b));
        for (int i = 7; i >= 4; i--) begin
            expect_item("abort_bit", int'(abort_msb[i]));
            read_bit(b);
            observe(int'(b));
        end
        bus_stop();
        check("abort_sda_released", int'(SDA === 1'b0), 0);
        check("abort_busy", int'(Busy), 0);
        check("abort_no_readdone", rd_cnt, exp_done);
        check("abort_pointer", int'(Pointer), int'(model_ptr));
        transaction(7'h4A, 1'b1, 2, 8'h00, 1'b0, 16'h0000);

        // Reset during the LSB; the bit being presented (bit 4 of 8'h80) is a 0
        Temperature = 16'h1A80;
        bus_start();
        expect_item("rst_addr_ack", 0);
        write_byte(8'h95, b);
        observe(int'(b));
        expect_item("rst_msb", 8'h1A);
        read_byte(d, 1'b0);
        observe(int'(d));
        for (int i = 7; i >= 5; i--) begin
            expect_item("rst_lsb_bit", int'(Temperature[i]));
            read_bit(b);
            observe(int'(b));
        end
        check("rst_sda_driven_before", int'(SDA === 1'b0), 1);
        #3;
        Reset = 1'b0;
        #1;
        check("rst_sda_released", int'(SDA === 1'b0), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_pointer", int'(Pointer), 0);
        check("rst_readdone", int'(ReadDone), 0);
        model_ptr = 8'h00;
        tick(2);
        Reset = 1'b1;
        tick(Q);
        bus_stop();
        transaction(7'h4A, 1'b1, 3, 8'h00, 1'b0, 16'h0000);

        // Randomized transactions
        for (int t = 0; t < 14; t++) begin
            ChipSelect  = 3'($urandom);
            Temperature = 16'($urandom);
            a7 = ($urandom_range(0, 3) != 0) ? {4'b1001, ChipSelect} : 7'($urandom);
            transaction(a7, 1'($urandom), int'($urandom_range(1, 4)), 8'($urandom),
                        1'($urandom), 16'($urandom));
        end

        tick(4);
        check("scoreboard_drained", exp_name.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_temp_sensor_responder.md
Name: i2c_temp_sensor_responder

Overview:
- I2C slave (responder) that emulates a TMP101-style temperature sensor on the shared SCL/SDA bus.
- Used as the bus partner of the team's I2C temperature reader: in simulation benches, and on a second board for FPGA-to-FPGA tests.
- Answers to address {4'b1001, ChipSelect}, returns a 16-bit temperature as MSB then LSB, and accepts a pointer byte on writes.
- Never drives SCL; drives SDA open-drain only.

Parameters:
- SyncStages, 2, flip-flop stages on SCL and SDA inputs before edge detection (minimum 2).
- DeviceID, 4'b1001, upper 4 bits of the 7-bit slave address.

Ports:
- clock  input  1  system clock (75-80 MHz); must be at least 20x SCL.
- Reset  input  1  reset.
- ChipSelect  input  3  lower 3 address bits (switches).
- Temperature  input  16  value to report; [15:8] = integer degrees C, [7:0] = fraction.
- SCL  input  1  bus clock from master.
- SDA  inout  1  bus data; block drives 0 or high-Z only.
- Pointer  output  8  last pointer byte written by the master.
- Busy  output  1  high from address match until STOP or restart.
- ReadDone  output  1  one-cycle pulse when the master NACKs the last read byte.

Behaviour:
- Clocking and reset:
  - One clock, clock. Reset is asynchronous and active-low.
  - Reset asserted: all state returns to IDLE and SDA is high-Z.
  - Reset values: Pointer = 8'h00, Busy = 0, ReadDone = 0, shift register = 0, bit counter = 0.
- Input sampling:
  - SCL and SDA pass through SyncStages flip-flops before edge detection.
  - Edge detection compares the last two synchronized samples.
- Bus conditions:
  - START: SDA falls while SCL is high. From any state, go to ADDR with the bit counter cleared.
  - STOP: SDA rises while SCL is high. From any state, go to IDLE, release SDA, drop Busy.
- Timing rules:
  - Sample SDA on a synchronized SCL rising edge.
  - Change the SDA drive only on a synchronized SCL falling edge.
- State ADDR: shift in 8 bits MSB first. After the 8th rising edge, compare bits [7:1] with {DeviceID, ChipSelect}.
  - Match: go to ADDR_ACK, set Busy.
  - Mismatch: go to IGNORE (SDA stays high-Z until START or STOP).
- State ADDR_ACK:
  - Drive SDA low from the falling edge after bit 8 to the falling edge after the ACK clock.
  - On that ACK falling edge, latch Temperature into a 16-bit holding register so both bytes come from one sample.
  - R/W = 1 goes to READ_MSB; R/W = 0 goes to WRITE_PTR.
- State WRITE_PTR:
  - Shift in 8 bits, write them to Pointer, ACK (drive low for one SCL cycle).
  - Further write bytes are ACKed and discarded.
- State READ_MSB: present holding[15:8] MSB first. A 1 bit releases SDA; a 0 bit drives SDA low.
  - After bit 8, release SDA and sample the master's ACK on the 9th rising edge.
  - ACK (0): go to READ_LSB.
  - NACK (1): go to WAIT_STOP and pulse ReadDone.
- State READ_LSB: present holding[7:0] the same way.
  - On ACK, wrap to READ_MSB with the same holding value (no re-latch).
  - On NACK, go to WAIT_STOP and pulse ReadDone.
- State WAIT_STOP: SDA high-Z. Exit on STOP to IDLE, or on START to ADDR.
- Boundary conditions:
  - START or STOP mid-byte: abort immediately and release SDA within 1 clock of detection. No ReadDone, Pointer unchanged.
  - Temperature changes during a transfer: no effect until the next address ACK.
  - ChipSelect changes mid-transaction: takes effect only at the next address compare.
  - SDA transitions while SCL is high inside a byte are START/STOP by definition and take priority over data sampling.
  - Reset mid-transfer: SDA released asynchronously.
- SDA drive: the tristate is SDA = DriveLow ? 1'b0 : 1'bz. Nothing else drives SDA.
- Sizing: 3-bit bit counter plus a 9th-bit flag. Roughly 200-300 lines of RTL.

Decomposition:
- Shared package (or include file) holds:
  - state encodings: IDLE, ADDR, ADDR_ACK, WRITE_PTR, WRITE_ACK, READ_MSB, READ_LSB, WAIT_STOP, IGNORE;
  - the TMP101 DeviceID constant 4'b1001;
  - the pointer code 8'h00 for the temperature register.
- One sub-module: i2c_bus_conditioner. It does the synchronizers and SCL edge detection, and emits SclRise, SclFall, StartSeen, StopSeen and SdaSync.

Test Plan:
- Read hit: ChipSelect = 3'b010, Temperature = 16'h1A80, master sends START, 8'h95, ACKs byte 1, NACKs byte 2 -> address ACK low; bytes 8'h1A then 8'h80 on SDA; ReadDone pulses once; Busy drops after STOP.
- Address miss: ChipSelect = 3'b000, master sends 8'h93 -> SDA never driven low; master sees NACK; Busy stays 0.
- Pointer write: START, 8'h94, 8'h01, STOP with ChipSelect = 3'b010 -> two ACKs; Pointer = 8'h01 after the second ACK.
- Coherence: Temperature changes 16'h1900 -> 16'h1AFF between the MSB and LSB of one read -> master receives 8'h19, 8'h00.
- Abort: STOP inserted after 4 data bits of the MSB, then a fresh read -> SDA released within 1 clock of the STOP; no ReadDone; the new read returns correct bytes.
- Reset mid-read: Reset pulled low during READ_LSB bit 3 -> SDA high-Z immediately; all outputs at reset values; the next transaction works.
